noc_route_split: RTL and testbench

Clocked, parameterised two-way address-decoding split stage for the NoC router tree. It accepts one flit per handshake and decodes the address field in leaf-match or tree-bit mode. It reports the routing decision on a 1-bit select channel and enqueues the flit into a per-output FIFO. It sits at each router tree node, between the upstream link and two downstream links, and decouples them by DEPTH flits per output.

---
 rtl/noc_route_split.sv | 169 ++++++++++++++++
 tb/tb_noc_route_split.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_route_split.sv
// Two-way address-decoding split: hold register feeds one of two DEPTH-entry FIFOs with registered heads; optional per-output counters under NOC_ROUTE_STATS_EN.
// Accept-to-output latency 2 edges; s handshake and FIFO enqueue fire together, and a full target FIFO or s_ready=0 stalls the held flit (head-of-line).
module noc_route_split #(
    parameter int                W      = 9,
    parameter int                ADDR_W = 4,
    parameter logic [ADDR_W-1:0] ADDR   = 4'b0010,
    parameter logic [ADDR_W-1:0] MASK   = 4'b1110,
    parameter int                LEAF   = 1,
    parameter int                DEPTH  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [W-1:0] out0_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [W-1:0] out1_data,
    output logic         s_valid,
    input  logic         s_ready,
    output logic         s_data
`ifdef NOC_ROUTE_STATS_EN
    ,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    function automatic int lead_ones(input logic [ADDR_W-1:0] m);
        int k;
        k = 0;
        for (int i = ADDR_W - 1; i >= 0; i--)
            if (m[i] && (k == ADDR_W - 1 - i)) k++;
        return k;
    endfunction

    localparam int K    = lead_ones(MASK);
    localparam int TBIT = (K >= ADDR_W) ? 0 : ADDR_W - 1 - K;

    logic              held_q, held_d;
    logic [W-1:0]      hdata_q, hdata_d;
    logic [W-1:0]      mem_q [2][DEPTH];
    logic [W-1:0]      mem_d [2][DEPTH];
    logic [PW-1:0]     rd_q [2], rd_d [2], wr_q [2], wr_d [2];
    logic [CW-1:0]     cnt_q [2], cnt_d [2];
    logic [W-1:0]      head_q [2], head_d [2];
    logic [1:0]        full, enq, deq, out_rdy;
    logic              fire, route;
    logic [ADDR_W-1:0] a;

    assign a = hdata_q[W-1 -: ADDR_W];

    // A tree node whose mask is all ones is the root's pass-through side.
    generate
        if (LEAF != 0) begin : g_leaf
            assign route = ((a & MASK) != ADDR);
        end else if (K >= ADDR_W) begin : g_root
            assign route = 1'b1;
        end else begin : g_tree
            assign route = a[TBIT];
        end
    endgenerate

    assign out_rdy = {out1_ready, out0_ready};

    always_comb begin
        full = '0;
        deq  = '0;
        for (int n = 0; n < 2; n++) begin
            full[n] = (cnt_q[n] == CW'(DEPTH));
            deq[n]  = (cnt_q[n] != '0) && out_rdy[n];
        end
    end

    assign fire     = held_q && s_ready && !full[route];
    assign enq      = {fire && route, fire && !route};
    assign in_ready = !held_q || fire;

    always_comb begin
        held_d  = held_q;
        hdata_d = hdata_q;
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        if (fire) held_d = 1'b0;
        if (in_valid && in_ready) begin
            held_d  = 1'b1;
            hdata_d = in_data;
        end
        for (int n = 0; n < 2; n++) begin
            if (enq[n]) begin
                mem_d[n][wr_q[n]] = hdata_q;
                wr_d[n]           = wr_q[n] + PW'(1);
            end
            if (deq[n]) rd_d[n] = rd_q[n] + PW'(1);
            if (enq[n] && !deq[n])      cnt_d[n] = cnt_q[n] + CW'(1);
            else if (!enq[n] && deq[n]) cnt_d[n] = cnt_q[n] - CW'(1);
            // Head follows the next stored entry, or the incoming flit if it becomes the only one.
            if (deq[n] && (cnt_q[n] > CW'(1)))
                head_d[n] = mem_q[n][rd_q[n] + PW'(1)];
            else if (enq[n] && ((cnt_q[n] == '0) || deq[n]))
                head_d[n] = hdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q  <= 1'b0;
            hdata_q <= '0;
            for (int n = 0; n < 2; n++) begin
                rd_q[n]   <= '0;
                wr_q[n]   <= '0;
                cnt_q[n]  <= '0;
                head_q[n] <= '0;
            end
        end else begin
            held_q  <= held_d;
            hdata_q <= hdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out0_valid = (cnt_q[0] != '0);
    assign out1_valid = (cnt_q[1] != '0);
    assign out0_data  = head_q[0];
    assign out1_data  = head_q[1];
    assign s_valid    = held_q;
    assign s_data     = held_q && route;

`ifdef NOC_ROUTE_STATS_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (enq[0] && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
        if (enq[1] && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_noc_route_split.sv
// Bench for noc_route_split: queue-based model of accepted/held/buffered flits plus directed literal checks.
module tb_noc_route_split;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0, in_ready;
    logic [8:0] in_data = '0;
    logic       out0_valid, out0_ready = 1'b1;
    logic [8:0] out0_data;
    logic       out1_valid, out1_ready = 1'b1;
    logic [8:0] out1_data;
    logic       s_valid, s_ready = 1'b1, s_data;

    logic       t_in_valid = 1'b0;
    logic [8:0] t_in_data = '0;
    logic       ta_in_ready, ta_o0v, ta_o1v, ta_sv, ta_sd;
    logic [8:0] ta_o0d, ta_o1d;
    logic       tb_in_ready, tb_o0v, tb_o1v, tb_sv, tb_sd;
    logic [8:0] tb_o0d, tb_o1d;
`ifdef NOC_ROUTE_STATS_EN
    logic [15:0] cnt0, cnt1, ta_c0, ta_c1, tb_c0, tb_c1;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    noc_route_split dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data)
`ifdef NOC_ROUTE_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    noc_route_split #(.LEAF(0), .MASK(4'b1100)) dut_ta (
        .clk(clk), .reset(reset),
        .in_valid(t_in_valid), .in_ready(ta_in_ready), .in_data(t_in_data),
        .out0_valid(ta_o0v), .out0_ready(1'b1), .out0_data(ta_o0d),
        .out1_valid(ta_o1v), .out1_ready(1'b1), .out1_data(ta_o1d),
        .s_valid(ta_sv), .s_ready(1'b1), .s_data(ta_sd)
`ifdef NOC_ROUTE_STATS_EN
        , .cnt0(ta_c0), .cnt1(ta_c1)
`endif
    );

    noc_route_split #(.LEAF(0), .MASK(4'b1111)) dut_tb (
        .clk(clk), .reset(reset),
        .in_valid(t_in_valid), .in_ready(tb_in_ready), .in_data(t_in_data),
        .out0_valid(tb_o0v), .out0_ready(1'b1), .out0_data(tb_o0d),
        .out1_valid(tb_o1v), .out1_ready(1'b1), .out1_data(tb_o1d),
        .s_valid(tb_sv), .s_ready(1'b1), .s_data(tb_sd)
`ifdef NOC_ROUTE_STATS_EN
        , .cnt0(tb_c0), .cnt1(tb_c1)
`endif
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk9(input string nm, input logic [8:0] act, input logic [8:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Leaf decode with the default ADDR/MASK.
    function automatic logic mr(input logic [3:0] a);
        return ((a & 4'b1110) == 4'b0010) ? 1'b0 : 1'b1;
    endfunction

    logic [8:0] pend[$];
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    always @(negedge clk) begin : cmp
        logic r, sf, exp_ir, acc;
        int   tsz;
        if (reset) begin
            pend.delete();
            q0.delete();
            q1.delete();
        end else begin
            r      = (pend.size() != 0) ? mr(pend[0][8:5]) : 1'b0;
            tsz    = r ? q1.size() : q0.size();
            sf     = (pend.size() != 0) && s_ready && (tsz < DEPTH);
            exp_ir = (pend.size() == 0) || sf;
            chk1("in_ready", in_ready, exp_ir);
            chk1("s_valid", s_valid, pend.size() != 0);
            if (pend.size() != 0) chk1("s_data", s_data, r);
            chk1("out0_valid", out0_valid, q0.size() != 0);
            if (q0.size() != 0) chk9("out0_data", out0_data, q0[0]);
            chk1("out1_valid", out1_valid, q1.size() != 0);
            if (q1.size() != 0) chk9("out1_data", out1_data, q1[0]);
            acc = in_valid && exp_ir;
            if (out0_ready && q0.size() != 0) void'(q0.pop_front());
            if (out1_ready && q1.size() != 0) void'(q1.pop_front());
            if (sf) begin
                if (r) q1.push_back(pend[0]);
                else   q0.push_back(pend[0]);
                void'(pend.pop_front());
            end
            if (acc) pend.push_back(in_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [8:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk1("send_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out0_valid", out0_valid, 1'b0);
        chk1("rst_out1_valid", out1_valid, 1'b0);
        chk1("rst_s_valid", s_valid, 1'b0);
        chk1("rst_s_data", s_data, 1'b0);
        chk9("rst_out0_data", out0_data, 9'h000);
        chk9("rst_out1_data", out1_data, 9'h000);
        tick(3);
        reset = 1'b0;
        tick(1);

        // Leaf routing: 0011 -> out0, 0100 -> out1
        in_valid = 1'b1;
        in_data  = {4'b0011, 5'd1};
        tick(1);
        in_data  = {4'b0100, 5'd2};
        @(negedge clk);
        chk1("leaf_s_valid", s_valid, 1'b1);
        chk1("leaf_s_data0", s_data, 1'b0);
        chk1("leaf_out0_early", out0_valid, 1'b0);
        tick(1);
        in_valid = 1'b0;
        @(negedge clk);
        chk1("leaf_out0_valid", out0_valid, 1'b1);
        chk9("leaf_out0_data", out0_data, {4'b0011, 5'd1});
        chk1("leaf_s_data1", s_data, 1'b1);
        tick(1);
        @(negedge clk);
        chk1("leaf_out1_valid", out1_valid, 1'b1);
        chk9("leaf_out1_data", out1_data, {4'b0100, 5'd2});
        tick(4);

        // Output backpressure: 2 buffered, 1 held, 4th stalls
        out0_ready = 1'b0;
        for (int i = 1; i <= 3; i++) send({4'b0010, 5'(i)});
        in_valid = 1'b1;
        in_data  = {4'b0010, 5'd4};
        @(negedge clk);
        chk1("bp_in_ready", in_ready, 1'b0);
        tick(1);
        @(negedge clk);
        chk1("bp_in_ready2", in_ready, 1'b0);
        chk1("bp_s_valid", s_valid, 1'b1);
        chk1("bp_out0_valid", out0_valid, 1'b1);
        chk9("bp_out0_head", out0_data, {4'b0010, 5'd1});
        tick(1);
        out0_ready = 1'b1;
        send({4'b0010, 5'd4});
        tick(8);
        chk1("bp_drained", out0_valid, 1'b0);

        // Select-channel backpressure
        s_ready = 1'b0;
        send({4'b0100, 5'd9});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("sbp_in_ready", in_ready, 1'b0);
            chk1("sbp_out1_valid", out1_valid, 1'b0);
            tick(1);
        end
        s_ready = 1'b1;
        @(negedge clk);
        chk1("sbp_s_valid", s_valid, 1'b1);
        chk1("sbp_no_enq", out1_valid, 1'b0);
        tick(1);
        @(negedge clk);
        chk1("sbp_out1_valid_after", out1_valid, 1'b1);
        chk9("sbp_out1_data", out1_data, {4'b0100, 5'd9});
        chk1("sbp_s_valid_after", s_valid, 1'b0);
        tick(3);

        // Mid-operation reset
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send({4'b0010, 5'd10});
        send({4'b0100, 5'd11});
        send({4'b0011, 5'd12});
        tick(1);
        @(negedge clk);
        chk1("pre_rst_out0", out0_valid, 1'b1);
        chk1("pre_rst_out1", out1_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("mid_rst_out0", out0_valid, 1'b0);
        chk1("mid_rst_out1", out1_valid, 1'b0);
        chk1("mid_rst_s_valid", s_valid, 1'b0);
        tick(2);
        reset = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);
        chk1("post_rst_out0", out0_valid, 1'b0);
        tick(1);

`ifdef NOC_ROUTE_STATS_EN
        send({4'b0010, 5'd1});
        send({4'b0100, 5'd2});
        send({4'b0011, 5'd3});
        send({4'b1000, 5'd4});
        send({4'b0010, 5'd5});
        tick(5);
        chk16("cnt0", cnt0, 16'd3);
        chk16("cnt1", cnt1, 16'd2);
        force dut.cnt0_q = 16'hFFFF;
        #1;
        release dut.cnt0_q;
        send({4'b0010, 5'd6});
        tick(4);
        chk16("cnt0_sat", cnt0, 16'hFFFF);
        chk16("cnt1_hold", cnt1, 16'd2);
`endif

        // Tree mode: MASK=1100 picks a[1]; MASK=1111 always routes to out1
        t_in_valid = 1'b1;
        t_in_data  = {4'b1101, 5'd0};
        tick(1);
        t_in_valid = 1'b0;
        @(negedge clk);
        chk1("tree_a_sv", ta_sv, 1'b1);
        chk1("tree_a_1101", ta_sd, 1'b0);
        chk1("tree_b_1101", tb_sd, 1'b1);
        tick(3);
        t_in_valid = 1'b1;
        t_in_data  = {4'b0010, 5'd0};
        tick(1);
        t_in_valid = 1'b0;
        @(negedge clk);
        chk1("tree_a_0010", ta_sd, 1'b1);
        chk1("tree_b_0010", tb_sd, 1'b1);
        tick(3);
        t_in_valid = 1'b1;
        t_in_data  = {4'b0000, 5'd0};
        tick(1);
        t_in_valid = 1'b0;
        @(negedge clk);
        chk1("tree_a_0000", ta_sd, 1'b0);
        chk1("tree_b_0000", tb_sd, 1'b1);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
